exe_decode_stage: RTL and testbench

EXE_DECODE_STAGE -- requirements
Module: exe_decode_stage

---
 rtl/exe_decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_exe_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_decode_stage.sv
// exe_decode_stage: decodes a micro-op into resolved ALU operands, branch and
// jump controls, and holds it in a two-entry skid buffer (output register plus
// skid register). The upstream ready is a plain register output.
// Micro-opcode encoding of in_uopc (6 bits):
//   0 lui, 1 auipc, 2 jal, 3 jalr, 4..9 beq bne blt bge bltu bgeu,
//   10..18 addi slti sltiu xori ori andi slli srli srai,
//   19..28 add sub sll slt sltu xoro srl sra oro ando; others are illegal.
// Optional feature macro: EXE_DECODE_PERF_EN adds perf_issued/perf_stall counters.
module exe_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_uopc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_opa,
    output logic [XLEN-1:0]  out_opb,
    output logic [3:0]       out_alu_op,
    output logic             out_is_branch,
    output logic             out_is_jump,
    output logic             out_illegal,
    output logic [2:0]       out_br_cond,
    output logic [XLEN-1:0]  out_jump_base
`ifdef EXE_DECODE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    typedef enum logic [5:0] {
        UOP_LUI  = 6'd0,  UOP_AUIPC = 6'd1,  UOP_JAL  = 6'd2,  UOP_JALR  = 6'd3,
        UOP_BEQ  = 6'd4,  UOP_BNE   = 6'd5,  UOP_BLT  = 6'd6,  UOP_BGE   = 6'd7,
        UOP_BLTU = 6'd8,  UOP_BGEU  = 6'd9,
        UOP_ADDI = 6'd10, UOP_SLTI  = 6'd11, UOP_SLTIU = 6'd12, UOP_XORI = 6'd13,
        UOP_ORI  = 6'd14, UOP_ANDI  = 6'd15, UOP_SLLI = 6'd16, UOP_SRLI  = 6'd17,
        UOP_SRAI = 6'd18,
        UOP_ADD  = 6'd19, UOP_SUB   = 6'd20, UOP_SLL  = 6'd21, UOP_SLT   = 6'd22,
        UOP_SLTU = 6'd23, UOP_XORO  = 6'd24, UOP_SRL  = 6'd25, UOP_SRA   = 6'd26,
        UOP_ORO  = 6'd27, UOP_ANDO  = 6'd28
    } uopc_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  opa;
        logic [XLEN-1:0]  opb;
        logic [3:0]       alu_op;
        logic             is_branch;
        logic             is_jump;
        logic             illegal;
        logic [2:0]       br_cond;
        logic [XLEN-1:0]  jump_base;
    } uop_t;

    // ALU operation shared by the immediate and register forms of each op
    function automatic alu_op_e alu_of(input uopc_e u);
        case (u)
            UOP_SUB:              return ALU_SUB;
            UOP_SLLI, UOP_SLL:    return ALU_SLL;
            UOP_SLTI, UOP_SLT:    return ALU_SLT;
            UOP_SLTIU, UOP_SLTU:  return ALU_SLTU;
            UOP_XORI, UOP_XORO:   return ALU_XOR;
            UOP_SRLI, UOP_SRL:    return ALU_SRL;
            UOP_SRAI, UOP_SRA:    return ALU_SRA;
            UOP_ORI, UOP_ORO:     return ALU_OR;
            UOP_ANDI, UOP_ANDO:   return ALU_AND;
            default:              return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] br_cond_of(input uopc_e u);
        case (u)
            UOP_BNE:  return 3'd1;
            UOP_BLT:  return 3'd4;
            UOP_BGE:  return 3'd5;
            UOP_BLTU: return 3'd6;
            UOP_BGEU: return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    uopc_e uopc;
    uop_t  dec;
    uop_t  out_q, out_d, skid_q, skid_d;
    logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic  in_fire;

    assign uopc    = uopc_e'(in_uopc);
    assign in_fire = in_valid && in_ready;

    // Decode the incoming uop into resolved operands and control fields
    always_comb begin
        dec        = '0;
        dec.tag    = in_tag;
        dec.alu_op = ALU_ADD;
        case (uopc)
            UOP_LUI: begin
                dec.alu_op = ALU_PASSB;
                dec.opb    = in_imm;
            end
            UOP_AUIPC: begin
                dec.opa = in_pc;
                dec.opb = in_imm;
            end
            UOP_JAL, UOP_JALR: begin
                dec.opa       = in_pc;
                dec.opb       = XLEN'(4);
                dec.is_jump   = 1'b1;
                dec.jump_base = (uopc == UOP_JAL) ? in_pc : in_rs1;
            end
            UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU: begin
                dec.alu_op    = ALU_SUB;
                dec.opa       = in_rs1;
                dec.opb       = in_rs2;
                dec.is_branch = 1'b1;
                dec.br_cond   = br_cond_of(uopc);
            end
            UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI, UOP_ANDI: begin
                dec.alu_op = alu_of(uopc);
                dec.opa    = in_rs1;
                dec.opb    = in_imm;
            end
            UOP_SLLI, UOP_SRLI, UOP_SRAI: begin
                dec.alu_op = alu_of(uopc);
                dec.opa    = in_rs1;
                dec.opb    = {{(XLEN-5){1'b0}}, in_imm[4:0]};
            end
            UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU,
            UOP_XORO, UOP_SRL, UOP_SRA, UOP_ORO, UOP_ANDO: begin
                dec.alu_op = alu_of(uopc);
                dec.opa    = in_rs1;
                dec.opb    = in_rs2;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Skid-buffer control: refill the output from skid first so order is kept
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // Pipeline state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready      = !skid_valid_q;
    assign out_valid     = out_valid_q;
    assign out_tag       = out_q.tag;
    assign out_opa       = out_q.opa;
    assign out_opb       = out_q.opb;
    assign out_alu_op    = out_q.alu_op;
    assign out_is_branch = out_q.is_branch;
    assign out_is_jump   = out_q.is_jump;
    assign out_illegal   = out_q.illegal;
    assign out_br_cond   = out_q.br_cond;
    assign out_jump_base = out_q.jump_base;

`ifdef EXE_DECODE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;

    // Count output handshakes and stalled cycles; flush leaves them alone
    always_comb begin
        perf_issued_d = perf_issued_q + 32'(out_valid_q && out_ready);
        perf_stall_d  = perf_stall_q + 32'(out_valid_q && !out_ready);
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_exe_decode_stage.sv
// tb_exe_decode_stage: scoreboard bench for exe_decode_stage. Accepted uops are
// decoded by a table-driven reference model and queued; a monitor pops and
// compares on every output handshake and checks hold-stability during stalls.
// Build with EXE_DECODE_PERF_EN defined to also exercise the perf counters.
module tb_exe_decode_stage;

    localparam logic [5:0] OP_JAL = 6'd2, OP_JALR = 6'd3, OP_BLTU = 6'd8;
    localparam logic [5:0] OP_ADDI = 6'd10, OP_ADD = 6'd19, OP_BAD = 6'd45;

    localparam int BR_TAB [6] = '{0, 1, 4, 5, 6, 7};
    localparam int I_TAB  [9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [3:0]  alu_op;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
        logic [2:0]  br_cond;
        logic [31:0] jump_base;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_uopc, in_tag, out_tag;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [31:0] out_opa, out_opb, out_jump_base;
    logic [3:0]  out_alu_op;
    logic        out_is_branch, out_is_jump, out_illegal;
    logic [2:0]  out_br_cond;
`ifdef EXE_DECODE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    exp_t expQ[$];
    exp_t curOut;
    exp_t heldOut;
    logic stallPrev = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exe_decode_stage #(.XLEN(32), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uopc(in_uopc),
        .in_tag(in_tag), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_opa(out_opa), .out_opb(out_opb), .out_alu_op(out_alu_op),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
        .out_illegal(out_illegal), .out_br_cond(out_br_cond),
        .out_jump_base(out_jump_base)
`ifdef EXE_DECODE_PERF_EN
        ,
        .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    assign curOut = {out_tag, out_opa, out_opb, out_alu_op, out_is_branch,
                     out_is_jump, out_illegal, out_br_cond, out_jump_base};

    // Reference decode from the opcode classes and lookup tables
    function automatic exp_t refModel(input logic [5:0] op, input logic [5:0] tag,
                                      input logic [31:0] pc, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        int   k;
        e     = '0;
        e.tag = tag;
        k     = int'(op);
        if (k == 0) begin
            e.alu_op = 4'd10;
            e.opb    = imm;
        end else if (k == 1) begin
            e.opa = pc;
            e.opb = imm;
        end else if (k == 2 || k == 3) begin
            e.opa       = pc;
            e.opb       = 32'd4;
            e.is_jump   = 1'b1;
            e.jump_base = (k == 2) ? pc : rs1;
        end else if (k >= 4 && k <= 9) begin
            e.alu_op    = 4'd1;
            e.opa       = rs1;
            e.opb       = rs2;
            e.is_branch = 1'b1;
            e.br_cond   = 3'(BR_TAB[k-4]);
        end else if (k >= 10 && k <= 18) begin
            e.alu_op = 4'(I_TAB[k-10]);
            e.opa    = rs1;
            e.opb    = (k >= 16) ? (imm % 32) : imm;
        end else if (k >= 19 && k <= 28) begin
            e.alu_op = 4'(k - 19);
            e.opa    = rs1;
            e.opb    = rs2;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; records the expected result of an accepted uop
    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] tag,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_uopc   = op;
        in_tag    = tag;
        in_pc     = pc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (fl)
            expQ.delete();
        else if (in_valid && in_ready)
            expQ.push_back(refModel(op, tag, pc, rs1, rs2, imm));
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expQ.delete();
        rst = 1'b0;
    endtask

    // Monitor: compare every output handshake and hold-stability under stall
    always @(negedge clk) begin
        if (rst || flush) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checks++;
                if ({out_valid, curOut} !== {1'b1, heldOut}) begin
                    failures++;
                    $display("[TB] FAIL hold: got %b/%h, expected 1/%h", out_valid, curOut, heldOut);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_output: got %h, expected none", curOut);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    if (curOut !== e) begin
                        failures++;
                        $display("[TB] FAIL payload: got %h, expected %h", curOut, e);
                    end
                end
            end
            stallPrev = out_valid && !out_ready;
            heldOut   = curOut;
        end
    end

    initial begin
        in_uopc = '0; in_tag = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        resetDut();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_payload_zero", 64'(curOut != '0), 64'd0);

        $display("[TB] addi decode");
        applyStimulus(1'b1, OP_ADDI, 6'd3, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b0);
        checkOutput("addi_valid", 64'(out_valid), 64'd1);
        checkOutput("addi_alu", 64'(out_alu_op), 64'd0);
        checkOutput("addi_opa", 64'(out_opa), 64'd5);
        checkOutput("addi_opb", 64'(out_opb), 64'hFFFF_FFFD);
        idleCycle(1'b1);

        $display("[TB] bltu decode");
        applyStimulus(1'b1, OP_BLTU, 6'd4, 32'h40, 32'd1, 32'd2, 32'h77, 1'b1, 1'b0);
        checkOutput("bltu_alu", 64'(out_alu_op), 64'd1);
        checkOutput("bltu_branch", 64'(out_is_branch), 64'd1);
        checkOutput("bltu_cond", 64'(out_br_cond), 64'd6);
        checkOutput("bltu_opa", 64'(out_opa), 64'd1);
        checkOutput("bltu_opb", 64'(out_opb), 64'd2);
        idleCycle(1'b1);

        $display("[TB] jalr and illegal decode");
        applyStimulus(1'b1, OP_JALR, 6'd5, 32'h100, 32'h2000, 32'd9, 32'd0, 1'b1, 1'b0);
        checkOutput("jalr_opa", 64'(out_opa), 64'h100);
        checkOutput("jalr_opb", 64'(out_opb), 64'd4);
        checkOutput("jalr_jump", 64'(out_is_jump), 64'd1);
        checkOutput("jalr_base", 64'(out_jump_base), 64'h2000);
        applyStimulus(1'b1, OP_BAD, 6'd6, 32'h100, 32'h55, 32'h66, 32'h77, 1'b1, 1'b0);
        checkOutput("illegal_valid", 64'(out_valid), 64'd1);
        checkOutput("illegal_flag", 64'(out_illegal), 64'd1);
        checkOutput("illegal_opa", 64'(out_opa), 64'd0);
        idleCycle(1'b1);

        $display("[TB] back-to-back into stalled output");
        checkOutput("bp_ready_a", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, OP_ADD, 6'd10, 32'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
        checkOutput("bp_ready_b", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, OP_ADD, 6'd11, 32'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        checkOutput("bp_ready_c", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, OP_ADD, 6'd12, 32'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
        checkOutput("bp_head_a", 64'(out_tag), 64'd10);
        idleCycle(1'b1);
        checkOutput("bp_head_b", 64'(out_tag), 64'd11);
        idleCycle(1'b1);
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        $display("[TB] flush with two held uops");
        applyStimulus(1'b1, OP_ADD, 6'd20, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, OP_ADD, 6'd21, 32'd0, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, OP_ADD, 6'd22, 32'd0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        idleCycle(1'b1);
        checkOutput("flush_dropped", 64'(out_valid), 64'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 15) == 0) ? OP_BAD : 6'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 3) != 0, op, 6'($urandom), $urandom, $urandom,
                          $urandom, $urandom, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 4; i++)
            idleCycle(1'b1);
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, OP_JAL, 6'd30, 32'h10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, OP_JAL, 6'd31, 32'h20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        resetDut();
        checkOutput("rst_stall_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_stall_ready", 64'(in_ready), 64'd1);
        idleCycle(1'b1);
        checkOutput("rst_stall_silent", 64'(out_valid), 64'd0);

`ifdef EXE_DECODE_PERF_EN
        $display("[TB] perf counters");
        resetDut();
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, OP_ADD, 6'(i), 32'd0, 32'(i), 32'd1, 32'd0, 1'b1, 1'b0);
        idleCycle(1'b1);
        applyStimulus(1'b1, OP_ADD, 6'd40, 32'd0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            idleCycle(1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("perf_issued", 64'(perf_issued), 64'd10);
        checkOutput("perf_stall", 64'(perf_stall), 64'd4);
        resetDut();
        checkOutput("perf_issued_rst", 64'(perf_issued), 64'd0);
        checkOutput("perf_stall_rst", 64'(perf_stall), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
